// File: rtl/memory_bus.sv
// Address decoder and access sequencer between the 6502 memory interface and
// the on-chip RAM, synchronous ROM and I/O registers (LEDs, ports, timer).
module memory_bus #(
  parameter int ROM_BITS   = 10,
  parameter int TIMER_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         address,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  input  logic                bus_read,
  input  logic                bus_write,
  output logic                bus_ready,
  output logic [8:0]          ram_address,
  output logic [7:0]          ram_data_in,
  input  logic [7:0]          ram_data_out,
  output logic                ram_write_enable,
  output logic [ROM_BITS-1:0] rom_address,
  input  logic [7:0]          rom_data,
  output logic [7:0]          ioport_a,
  input  logic [7:0]          ioport_b,
  output logic [7:0]          leds,
  output logic [1:0]          fsm_state
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ROM_WAIT = 2'd1;
  localparam logic [1:0] S_ACK      = 2'd2;

  // Handshake: bus_read/bus_write are held until the single-cycle bus_ready
  // strobe; the CPU drops them in the ACK cycle, and a request still high in
  // the following IDLE cycle is a new access.
  logic [1:0]            state_q, state_d;
  logic [15:0]           addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  is_write_q, is_write_d;
  logic [7:0]            data_out_q, data_out_d;
  logic [7:0]            ioport_a_q, ioport_a_d;
  logic [7:0]            leds_q, leds_d;
  logic [7:0]            snap_q, snap_d;
  logic [TIMER_BITS-1:0] timer_q;

  logic        start;
  logic [15:0] cur_addr;
  logic        ram_hit, rom_hit;
  logic [15:0] timer16;
  logic [7:0]  rd_data;

  // The incoming address is passed through in the starting IDLE cycle so the
  // combinational RAM answers in time and the synchronous ROM sees its address
  // one cycle before its data is sampled at the end of ROM_WAIT.
  assign start    = (state_q == S_IDLE) && (bus_read || bus_write);
  assign cur_addr = start ? address : addr_q;
  assign ram_hit  = (cur_addr[15:9] == 7'd0);
  assign rom_hit  = (cur_addr[15:14] == 2'b11);
  assign timer16  = 16'(timer_q);

  always_comb begin
    rd_data = 8'hFF;
    if (ram_hit) begin
      rd_data = ram_data_out;
    end else if (rom_hit) begin
      rd_data = rom_data;
    end else begin
      case (cur_addr)
        16'h8000: rd_data = ioport_a_q;
        16'h8001: rd_data = ioport_b;
        16'h8002: rd_data = leds_q;
        16'h8004: rd_data = timer16[7:0];
        16'h8005: rd_data = snap_q;
        default:  rd_data = 8'hFF;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    data_out_d = data_out_q;
    ioport_a_d = ioport_a_q;
    leds_d     = leds_q;
    snap_d     = snap_q;
    case (state_q)
      S_IDLE: begin
        if (bus_read || bus_write) begin
          addr_d     = address;
          wdata_d    = data_in;
          is_write_d = bus_write;
          if (!bus_write && rom_hit) begin
            state_d = S_ROM_WAIT;
          end else begin
            state_d = S_ACK;
            if (!bus_write) begin
              data_out_d = rd_data;
              // High byte is frozen here so a later 0x8005 read pairs coherently.
              if (address == 16'h8004) snap_d = timer16[15:8];
            end
          end
        end
      end
      S_ROM_WAIT: begin
        data_out_d = rom_data;
        state_d    = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (is_write_q) begin
          if (addr_q == 16'h8000) ioport_a_d = wdata_q;
          if (addr_q == 16'h8002) leds_d     = wdata_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= 16'd0;
      wdata_q    <= 8'd0;
      is_write_q <= 1'b0;
      data_out_q <= 8'd0;
      ioport_a_q <= 8'd0;
      leds_q     <= 8'd0;
      snap_q     <= 8'd0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      data_out_q <= data_out_d;
      ioport_a_q <= ioport_a_d;
      leds_q     <= leds_d;
      snap_q     <= snap_d;
      timer_q    <= timer_q + {{(TIMER_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign data_out         = data_out_q;
  assign bus_ready        = (state_q == S_ACK);
  assign ram_address      = cur_addr[8:0];
  assign ram_data_in      = wdata_q;
  assign ram_write_enable = (state_q == S_ACK) && is_write_q && (addr_q[15:9] == 7'd0);
  assign rom_address      = cur_addr[ROM_BITS-1:0];
  assign ioport_a         = ioport_a_q;
  assign leds             = leds_q;
  assign fsm_state        = state_q;

endmodule

// File: tb/tb_memory_bus.sv
// Directed bench for memory_bus: RAM/ROM/I-O accesses, latencies, timer pair
// coherence and wrap, reset mid-access and read/write priority.
module tb_memory_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        bus_read, bus_write, bus_ready;
  logic [8:0]  ram_address;
  logic [7:0]  ram_data_in, ram_data_out;
  logic        ram_write_enable;
  logic [9:0]  rom_address;
  logic [7:0]  rom_data;
  logic [7:0]  ioport_a, ioport_b, leds;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  memory_bus #(.ROM_BITS(10), .TIMER_BITS(16)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .data_out(data_out), .bus_read(bus_read), .bus_write(bus_write),
    .bus_ready(bus_ready), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .ram_write_enable(ram_write_enable),
    .rom_address(rom_address), .rom_data(rom_data), .ioport_a(ioport_a),
    .ioport_b(ioport_b), .leds(leds), .fsm_state(fsm_state)
  );

  // RAM model: combinational read, write on the clock edge.
  logic [7:0] ram_mem [0:511];
  assign ram_data_out = ram_mem[ram_address];
  always @(posedge clk) if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;

  // Synchronous ROM model: data one clock after the address.
  always @(posedge clk)
    rom_data <= (rom_address == 10'h123) ? 8'hA9 : (rom_address[7:0] ^ 8'h5A);

  // Reference free-running counter.
  logic [15:0] tcnt;
  always @(posedge clk or negedge reset)
    if (!reset) tcnt <= 16'd0;
    else        tcnt <= tcnt + 16'd1;

  int checks   = 0;
  int failures = 0;

  logic       ack_we;
  logic [8:0] ack_ra;
  logic [7:0] ack_rd, ack_do;
  logic [15:0] exp_t;
  logic        found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one access from IDLE and checks the ready strobe lands exactly `lat`
  // cycles later; captures the ACK-cycle outputs for the caller.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [7:0] d, input int lat, input string tag);
    bus_read  = rd;
    bus_write = wr;
    address   = a;
    data_in   = d;
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (c < lat) begin
        chk({tag, "_wait_ready"}, bus_ready, 0);
        chk({tag, "_wait_we"}, ram_write_enable, 0);
      end
    end
    chk({tag, "_ready"}, bus_ready, 1);
    ack_we = ram_write_enable;
    ack_ra = ram_address;
    ack_rd = ram_data_in;
    ack_do = data_out;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    tick();
    chk({tag, "_ready_drop"}, bus_ready, 0);
    chk({tag, "_we_drop"}, ram_write_enable, 0);
  endtask

  initial begin
    reset     = 1'b0;
    address   = 16'h0000;
    data_in   = 8'h00;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    ioport_b  = 8'h55;
    for (int i = 0; i < 512; i++) ram_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_ready", bus_ready, 0);
    chk("rst_ram_addr", ram_address, 0);
    chk("rst_ram_din", ram_data_in, 0);
    chk("rst_we", ram_write_enable, 0);
    chk("rst_rom_addr", rom_address, 0);
    chk("rst_ioport_a", ioport_a, 0);
    chk("rst_leds", leds, 0);
    chk("rst_state", fsm_state, 0);

    access(1'b0, 1'b1, 16'h0005, 8'h3C, 1, "ram_wr");
    chk("ram_wr_we", ack_we, 1);
    chk("ram_wr_addr", ack_ra, 9'h005);
    chk("ram_wr_din", ack_rd, 8'h3C);
    chk("ram_wr_mem", ram_mem[5], 8'h3C);

    access(1'b1, 1'b0, 16'h0005, 8'h00, 1, "ram_rd");
    chk("ram_rd_data", ack_do, 8'h3C);
    chk("ram_rd_we", ack_we, 0);

    address  = 16'hC123;
    bus_read = 1'b1;
    #1;
    chk("rom_addr", rom_address, 10'h123);
    access(1'b1, 1'b0, 16'hC123, 8'h00, 2, "rom_rd");
    chk("rom_rd_data", ack_do, 8'hA9);

    access(1'b0, 1'b1, 16'hC123, 8'h77, 1, "rom_wr");
    chk("rom_wr_we", ack_we, 0);
    chk("rom_wr_ioa", ioport_a, 0);
    chk("rom_wr_leds", leds, 0);

    access(1'b0, 1'b1, 16'h8002, 8'h81, 1, "leds_wr");
    chk("leds_val", leds, 8'h81);
    access(1'b0, 1'b1, 16'h8000, 8'h7E, 1, "ioa_wr");
    chk("ioa_val", ioport_a, 8'h7E);
    chk("ioa_leds_kept", leds, 8'h81);
    access(1'b1, 1'b0, 16'h8001, 8'h00, 1, "iob_rd");
    chk("iob_data", ack_do, 8'h55);
    access(1'b1, 1'b0, 16'h8002, 8'h00, 1, "leds_rd");
    chk("leds_rd_data", ack_do, 8'h81);

    access(1'b1, 1'b0, 16'h9000, 8'h00, 1, "unmap_rd");
    chk("unmap_rd_data", ack_do, 8'hFF);
    access(1'b0, 1'b1, 16'h9000, 8'hAA, 1, "unmap_wr");
    chk("unmap_wr_we", ack_we, 0);
    chk("unmap_wr_leds", leds, 8'h81);
    chk("unmap_wr_ioa", ioport_a, 8'h7E);
    chk("unmap_wr_mem0", ram_mem[0], 8'h00);

    // Timer pair read straddling a low-byte wrap.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (tcnt >= 16'h0100 && tcnt[7:0] == 8'hFD) found = 1'b1;
      else tick();
    end
    chk("timer_wait_found", found, 1);
    exp_t = tcnt;
    access(1'b1, 1'b0, 16'h8004, 8'h00, 1, "tmr_lo");
    chk("tmr_lo_data", ack_do, exp_t[7:0]);
    repeat (4) tick();
    access(1'b1, 1'b0, 16'h8005, 8'h00, 1, "tmr_hi");
    chk("tmr_hi_coherent", ack_do, exp_t[15:8]);

    // Full-width wrap.
    found = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      if (tcnt == 16'hFFFF) found = 1'b1;
      else tick();
    end
    chk("wrap_wait_found", found, 1);
    access(1'b1, 1'b0, 16'h8004, 8'h00, 1, "wrap_lo");
    chk("wrap_lo_data", ack_do, 8'hFF);
    access(1'b1, 1'b0, 16'h8005, 8'h00, 1, "wrap_hi");
    chk("wrap_hi_data", ack_do, 8'hFF);
    exp_t = tcnt;
    access(1'b1, 1'b0, 16'h8004, 8'h00, 1, "post_lo");
    chk("post_lo_data", ack_do, exp_t[7:0]);
    access(1'b1, 1'b0, 16'h8005, 8'h00, 1, "post_hi");
    chk("post_hi_zero", ack_do, 8'h00);

    // Leave a nonzero data_out so the reset clearing it is visible.
    access(1'b1, 1'b0, 16'h8000, 8'h00, 1, "pre_rst_rd");
    chk("pre_rst_data", ack_do, 8'h7E);

    bus_read = 1'b1;
    address  = 16'hC010;
    tick();
    chk("romwait_state", fsm_state, 1);
    reset = 1'b0;
    #1;
    chk("midrst_ready", bus_ready, 0);
    chk("midrst_state", fsm_state, 0);
    bus_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("inrst_ready", bus_ready, 0);
    end
    reset = 1'b1;
    #1;
    chk("rel_state", fsm_state, 0);
    chk("rel_data_out", data_out, 0);
    chk("rel_ioport_a", ioport_a, 0);
    chk("rel_leds", leds, 0);
    chk("rel_ram_addr", ram_address, 0);
    chk("rel_ram_din", ram_data_in, 0);
    chk("rel_rom_addr", rom_address, 0);
    chk("rel_we", ram_write_enable, 0);
    tick();
    chk("rel_no_ready", bus_ready, 0);
    access(1'b1, 1'b0, 16'h8005, 8'h00, 1, "rel_snap");
    chk("rel_snap_zero", ack_do, 8'h00);
    exp_t = tcnt;
    access(1'b1, 1'b0, 16'h8004, 8'h00, 1, "rel_tmr");
    chk("rel_tmr_lo", ack_do, exp_t[7:0]);

    access(1'b1, 1'b1, 16'h0003, 8'h99, 1, "both");
    chk("both_we", ack_we, 1);
    chk("both_addr", ack_ra, 9'h003);
    chk("both_mem", ram_mem[3], 8'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
